uart_tx_fifo: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/sync_fifo.sv | 77 +++++++
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic TXD_IDLE  = 1'b1;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the bus-side producer and the UART transmitter.
interface uart_tx_fifo_if;

  logic [uart_pkg::DATA_BITS-1:0] tx_data;
  logic                           tx_valid;
  logic                           tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive from the count flop.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointers, storage and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end plus 8N1 serialiser, LSB first.
// UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_fifo_if.slave                 bus,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [15:0] RELOAD = 16'(DIVISOR - 1);

  tx_state_t               state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic                    txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic [DATA_BITS-1:0]    fifo_head;

  assign bus.tx_ready = !fifo_full;
  assign push         = bus.tx_valid && !fifo_full;
  assign txd          = txd_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.tx_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencing: every bit lasts DIVISOR cycles, counter reloads on each advance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_head;
          txd_d     = 1'b0;
          cnt_d     = RELOAD;
          bit_idx_d = 3'd0;
          state_d   = START;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(fifo_head);
`endif
        end else begin
          txd_d = TXD_IDLE;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = RELOAD;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = PARITY;
`else
            txd_d   = TXD_IDLE;
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = RELOAD;
          txd_d   = TXD_IDLE;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_head;
            txd_d     = 1'b0;
            cnt_d     = RELOAD;
            bit_idx_d = 3'd0;
            state_d   = START;
`ifdef UART_TX_PARITY_EN
            parity_d  = even_parity(fifo_head);
`endif
          end else begin
            txd_d   = TXD_IDLE;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        txd_d   = TXD_IDLE;
        state_d = IDLE;
      end
    endcase
  end

  // Serialiser registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= {DATA_BITS{1'b0}};
      txd_q     <= TXD_IDLE;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
